// File: rtl/exec_sequencer.sv
// Run/step/breakpoint sequencer for the multicycle CPU.
// Produces the global clock enable and the cycle/instruction counters.
module exec_sequencer #(
  parameter int PC_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             fsm_at_if,
  input  logic             clr_cnt,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic run_q, step_q;
  logic armed_q, armed_d;
  logic started_q, started_d;
  logic bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  logic run_rise, step_rise;
  logic bp_match, stop, retire;

  always_comb begin
    run_rise  = run & ~run_q;
    step_rise = step & ~step_q;
    bp_match  = bp_en & armed_q & (pc == bp_addr);
    state_d   = state_q;
    armed_d   = armed_q;
    started_d = started_q;
    bp_hit_d  = bp_hit_q;
    stop      = 1'b0;
    cpu_en    = 1'b0;

    unique case (state_q)
      S_HALT: begin
        if (run_rise && !halt_req) begin
          state_d  = S_RUN;
          armed_d  = 1'b0;
          bp_hit_d = 1'b0;
        end else if (step_rise) begin
          state_d   = S_STEP;
          started_d = 1'b0;
          bp_hit_d  = 1'b0;
        end
      end
      S_RUN: begin
        stop   = fsm_at_if & (~run | halt_req | bp_match);
        cpu_en = ~stop;
        if (fsm_at_if && !stop) armed_d = 1'b1;
        if (stop) begin
          state_d = S_HALT;
          if (bp_match) bp_hit_d = 1'b1;
        end
      end
      S_STEP: begin
        // started guards the IF of the stepped instruction itself
        stop   = fsm_at_if & started_q;
        cpu_en = ~stop;
        if (fsm_at_if && !stop) started_d = 1'b1;
        if (stop) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase

    retire = fsm_at_if & cpu_en;

    if (clr_cnt) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      cyc_d = cpu_en ? cyc_q + CNT_W'(1) : cyc_q;
      ins_d = retire ? ins_q + CNT_W'(1) : ins_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_HALT;
      run_q     <= 1'b1;
      step_q    <= 1'b1;
      armed_q   <= 1'b0;
      started_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run;
      step_q    <= step;
      armed_q   <= armed_d;
      started_q <= started_d;
      bp_hit_q  <= bp_hit_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign mode      = state_q;
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: vector table, directed corner cases and
// random stimulus against an instruction-level reference model.
module tb_exec_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic run, step, halt_req, bp_en, fsm_at_if, clr_cnt;
  logic [5:0] bp_addr, pc;
  logic cpu_en, halted, bp_hit;
  logic [1:0] mode;
  logic [15:0] cycle_cnt, instr_cnt;
  logic cpu_en4, halted4, bp_hit4;
  logic [1:0] mode4;
  logic [3:0] cycle_cnt4, instr_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  exec_sequencer #(.PC_W(6), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .fsm_at_if(fsm_at_if), .clr_cnt(clr_cnt), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .mode(mode),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  exec_sequencer #(.PC_W(6), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .fsm_at_if(fsm_at_if), .clr_cnt(clr_cnt), .cpu_en(cpu_en4),
    .halted(halted4), .bp_hit(bp_hit4), .mode(mode4),
    .cycle_cnt(cycle_cnt4), .instr_cnt(instr_cnt4)
  );

  // Reference model: mode 0 halt, 1 run, 2 step; retirements since entry
  // replace per-state flags.
  int m_mode, m_cyc, m_ins, m_since;
  bit m_bp, m_prev_run, m_prev_step;
  bit x_en, x_stop, x_brk, x_ret, x_rr, x_sr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_ins = 0; m_since = 0;
    m_bp = 0; m_prev_run = 1; m_prev_step = 1;
  endtask

  task automatic drive(input bit r, s, h, be, input bit [5:0] ba, p,
                       input bit a, c);
    run = r; step = s; halt_req = h; bp_en = be;
    bp_addr = ba; pc = p; fsm_at_if = a; clr_cnt = c;
    #2;
    x_rr = r && !m_prev_run;
    x_sr = s && !m_prev_step;
    x_brk = 0; x_stop = 0;
    if (m_mode == 1) begin
      x_brk  = be && (m_since > 0) && (p == ba);
      x_stop = a && (!r || h || x_brk);
    end else if (m_mode == 2) begin
      x_stop = a && (m_since > 0);
    end
    x_en  = (m_mode != 0) && !x_stop;
    x_ret = a && x_en;
    chk("cpu_en", cpu_en, x_en);
    chk("cpu_en4", cpu_en4, x_en);
    chk("mode", mode, m_mode);
    chk("halted", halted, m_mode == 0);
    chk("bp_hit", bp_hit, m_bp);
    chk("cycle_cnt", cycle_cnt, m_cyc % 65536);
    chk("instr_cnt", instr_cnt, m_ins % 65536);
    chk("cycle_cnt4", cycle_cnt4, m_cyc % 16);
    chk("instr_cnt4", instr_cnt4, m_ins % 16);
  endtask

  task automatic advance();
    @(posedge clock);
    if (clr_cnt) begin
      m_cyc = 0; m_ins = 0;
    end else begin
      m_cyc += int'(x_en);
      m_ins += int'(x_ret);
    end
    if (m_mode == 0) begin
      if (x_rr && !halt_req) begin
        m_mode = 1; m_since = 0; m_bp = 0;
      end else if (x_sr) begin
        m_mode = 2; m_since = 0; m_bp = 0;
      end
    end else begin
      if (x_ret) m_since++;
      if (x_stop) begin
        if (m_mode == 1 && x_brk) m_bp = 1;
        m_mode = 0;
      end
    end
    m_prev_run = run;
    m_prev_step = step;
    #1;
  endtask

  task automatic cyc(input bit r, s, h, be, input bit [5:0] ba, p,
                     input bit a, c);
    drive(r, s, h, be, ba, p, a, c);
    advance();
  endtask

  task automatic do_reset(input bit r, s);
    run = r; step = s; halt_req = 0; bp_en = 0; bp_addr = 0; pc = 0;
    fsm_at_if = 1; clr_cnt = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  typedef struct {
    bit r, s, h, be;
    bit [5:0] ba, p;
    bit a, c;
    bit e_en;
    bit [1:0] e_mode;
    bit e_bp;
    int e_cyc, e_ins;
  } vec_t;

  vec_t tbl[28];

  initial begin
    bit rr, ss;
    tbl[0]  = '{0,0,0,0,0,0,1,0, 0,0,0, 0,0};
    tbl[1]  = '{0,1,0,0,0,0,1,0, 0,0,0, 0,0};
    tbl[2]  = '{0,1,0,0,0,0,1,0, 1,2,0, 0,0};
    tbl[3]  = '{0,1,0,0,0,0,0,0, 1,2,0, 1,1};
    tbl[4]  = '{0,1,0,0,0,0,0,0, 1,2,0, 2,1};
    tbl[5]  = '{0,1,0,0,0,0,0,0, 1,2,0, 3,1};
    tbl[6]  = '{0,1,0,0,0,1,1,0, 0,2,0, 4,1};
    tbl[7]  = '{0,0,0,1,5,3,1,0, 0,0,0, 4,1};
    tbl[8]  = '{1,0,0,1,5,3,1,0, 0,0,0, 4,1};
    tbl[9]  = '{1,0,0,1,5,3,1,0, 1,1,0, 4,1};
    tbl[10] = '{1,0,0,1,5,3,0,0, 1,1,0, 5,2};
    tbl[11] = '{1,0,0,1,5,3,0,0, 1,1,0, 6,2};
    tbl[12] = '{1,0,0,1,5,4,1,0, 1,1,0, 7,2};
    tbl[13] = '{1,0,0,1,5,4,0,0, 1,1,0, 8,3};
    tbl[14] = '{1,0,0,1,5,4,0,0, 1,1,0, 9,3};
    tbl[15] = '{1,0,0,1,5,5,1,0, 0,1,0, 10,3};
    tbl[16] = '{1,0,0,1,5,5,1,0, 0,0,1, 10,3};
    tbl[17] = '{0,0,0,1,5,5,1,0, 0,0,1, 10,3};
    tbl[18] = '{1,0,0,1,5,5,1,0, 0,0,1, 10,3};
    tbl[19] = '{1,0,0,1,5,5,1,0, 1,1,0, 10,3};
    tbl[20] = '{1,0,0,1,5,5,0,0, 1,1,0, 11,4};
    tbl[21] = '{1,0,0,1,5,5,0,0, 1,1,0, 12,4};
    tbl[22] = '{1,0,0,1,5,6,1,0, 1,1,0, 13,4};
    tbl[23] = '{0,0,0,1,5,6,0,0, 1,1,0, 14,5};
    tbl[24] = '{0,0,0,1,5,6,0,0, 1,1,0, 15,5};
    tbl[25] = '{0,0,0,1,5,6,0,0, 1,1,0, 16,5};
    tbl[26] = '{0,0,0,1,5,7,1,0, 0,1,0, 17,5};
    tbl[27] = '{0,0,0,1,5,7,1,0, 0,0,0, 17,5};

    do_reset(0, 0);
    chk("rst_halted", halted, 1);
    chk("rst_mode", mode, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_cycle", cycle_cnt, 0);

    // step, breakpoint stop/resume, run lowered mid-instruction
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].be, tbl[i].ba,
            tbl[i].p, tbl[i].a, tbl[i].c);
      chk($sformatf("tbl%0d_en", i), cpu_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_mode", i), mode, tbl[i].e_mode);
      chk($sformatf("tbl%0d_bp", i), bp_hit, tbl[i].e_bp);
      chk($sformatf("tbl%0d_cyc", i), cycle_cnt, tbl[i].e_cyc);
      chk($sformatf("tbl%0d_ins", i), instr_cnt, tbl[i].e_ins);
      advance();
    end

    // halt_req ignored in STEP
    cyc(0,0,0,0,0,0,1,1);
    cyc(0,1,1,0,0,8,1,0);
    cyc(0,1,1,0,0,8,1,0);
    cyc(0,1,1,0,0,8,0,0);
    cyc(0,1,1,0,0,9,1,0);
    chk("step_hreq_halted", halted, 1);
    chk("step_hreq_ins", instr_cnt, 1);
    chk("step_hreq_cyc", cycle_cnt, 2);
    // halt_req and step_rise in RUN
    cyc(1,0,0,0,0,9,1,0);
    cyc(1,0,0,0,0,9,1,0);
    cyc(1,1,0,0,0,9,0,0);
    chk("run_step_mode", mode, 1);
    cyc(1,1,1,0,0,9,0,0);
    chk("run_hreq_mid_mode", mode, 1);
    cyc(1,0,1,0,0,10,1,0);
    chk("run_hreq_halted", halted, 1);
    chk("run_hreq_cyc", cycle_cnt, 5);
    chk("run_hreq_ins", instr_cnt, 2);
    chk("run_hreq_bp", bp_hit, 0);
    // run_rise blocked by halt_req in HALT
    cyc(0,0,0,0,0,10,1,0);
    cyc(1,0,1,0,0,10,1,0);
    chk("halt_runrise_hreq", halted, 1);

    // step held through reset
    do_reset(0, 1);
    cyc(0,1,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,1,0);
    chk("held_step_halted", halted, 1);
    chk("held_step_cyc", cycle_cnt, 0);
    cyc(0,0,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,0,0);
    cyc(0,1,0,0,0,1,1,0);
    chk("held_step_ins", instr_cnt, 1);
    chk("held_step_cyc2", cycle_cnt, 2);
    chk("held_step_halted2", halted, 1);

    // clear priority at all-ones and wrap on the 4-bit counter
    cyc(0,0,0,0,0,0,1,1);
    cyc(1,0,0,0,0,0,1,0);
    for (int i = 0; i < 15; i++) cyc(1,0,0,0,0,1,(i % 3) == 0,0);
    chk("pre_clr_cyc4", cycle_cnt4, 15);
    chk("pre_clr_cyc", cycle_cnt, 15);
    cyc(1,0,0,0,0,1,0,1);
    chk("clr_cyc4", cycle_cnt4, 0);
    chk("clr_cyc", cycle_cnt, 0);
    chk("clr_ins", instr_cnt, 0);
    for (int i = 0; i < 16; i++) cyc(1,0,0,0,0,2,(i % 4) == 0,0);
    chk("wrap_cyc4", cycle_cnt4, 0);
    chk("wrap_cyc", cycle_cnt, 16);
    chk("wrap_ins4", instr_cnt4, 4);
    cyc(0,0,0,0,0,3,1,0);
    chk("wrap_stop", halted, 1);

    // random stimulus
    do_reset(0, 0);
    rr = 0; ss = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      if ($urandom_range(0, 5) == 0) ss = ~ss;
      cyc(rr, ss, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
